fm_audio_decimator: RTL and testbench

- Downstream neighbour of the FM phase-difference demodulator.
- Consumes the demodulator's unsigned 16-bit discriminator stream and produces an audio-rate stream for the audio output path.
- Uses accumulate-and-dump (boxcar) averaging over 2^L input samples, with rounding.
- Decimation ratio is selectable at runtime; AXI-Stream in and out, with full backpressure.

---
 rtl/fm_audio_decimator.sv | 152 +++++++++++++++
 tb/tb_fm_audio_decimator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_audio_decimator.sv
// Boxcar decimator for the FM discriminator stream: averages 2^L samples with rounding.
// Optional single-pole de-emphasis on the decimated samples when FM_DEEMPH_EN is defined.
module fm_audio_decimator #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG2               = 6,
  parameter int DEEMPH_SHIFT           = 3
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  input  logic [2:0]                          decim_log2,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast
);

  localparam int ACC_W = 16 + MAX_LOG2;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [2:0] MAX_L = 3'(MAX_LOG2);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [2:0]         l_active_reg, l_active_next;
  logic               last_seen_reg, last_seen_next;
  logic               out_valid_reg, out_valid_next;
  logic [15:0]        out_data_reg, out_data_next;
  logic               out_last_reg, out_last_next;

  logic [2:0]         l_req, l_eff;
  logic [CNT_W-1:0]   last_cnt;
  logic               is_final, out_free, accept;
  logic [15:0]        x;
  logic [ACC_W-1:0]   sum;
  logic [SUM_W-1:0]   rnd_term, sum_rnd, shifted;
  logic [15:0]        y, sample;
  logic               unused_inputs;

  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata};

  // The first beat of a window has not latched L yet, so it uses the live request.
  always_comb begin
    l_req           = (decim_log2 > MAX_L) ? MAX_L : decim_log2;
    l_eff           = (state_reg == IDLE) ? l_req : l_active_reg;
    last_cnt        = (CNT_W'(1) << l_eff) - CNT_W'(1);
    is_final        = (count_reg == last_cnt);
    out_free        = !out_valid_reg || m00_axis_tready;
    s00_axis_tready = s00_axis_aresetn && (!is_final || out_free);
    accept          = s00_axis_tvalid && s00_axis_tready;
  end

  always_comb begin
    x        = s00_axis_tdata[15:0];
    sum      = acc_reg + ACC_W'(x);
    rnd_term = (l_eff == 3'd0) ? '0 : (SUM_W'(1) << (l_eff - 3'd1));
    sum_rnd  = {1'b0, sum} + rnd_term;
    shifted  = sum_rnd >> l_eff;
    y        = (shifted > SUM_W'(16'hFFFF)) ? 16'hFFFF : shifted[15:0];
  end

`ifdef FM_DEEMPH_EN
  logic [15:0]        z_reg, z_next;
  logic signed [16:0] z_diff, z_step;

  // z moves toward y by (y - z)/2^DEEMPH_SHIFT; the 16-bit wrap-around add is exact.
  always_comb begin
    z_diff = $signed({1'b0, y}) - $signed({1'b0, z_reg});
    z_step = z_diff >>> DEEMPH_SHIFT;
    sample = z_reg + z_step[15:0];
    z_next = z_reg;
    if (accept && is_final)
      z_next = sample;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn)
      z_reg <= '0;
    else
      z_reg <= z_next;
  end
`else
  localparam int unused_deemph_shift = DEEMPH_SHIFT;
  assign sample = y;
`endif

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    l_active_next  = l_active_reg;
    last_seen_next = last_seen_reg;
    out_valid_next = out_valid_reg && !m00_axis_tready;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    if (accept) begin
      if (state_reg == IDLE)
        l_active_next = l_req;
      if (is_final) begin
        out_valid_next = 1'b1;
        out_data_next  = sample;
        out_last_next  = last_seen_reg | s00_axis_tlast;
        acc_next       = '0;
        count_next     = '0;
        last_seen_next = 1'b0;
        state_next     = IDLE;
      end else begin
        acc_next       = sum;
        count_next     = count_reg + CNT_W'(1);
        last_seen_next = last_seen_reg | s00_axis_tlast;
        state_next     = ACCUM;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      l_active_reg  <= '0;
      last_seen_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      l_active_reg  <= l_active_next;
      last_seen_reg <= last_seen_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign m00_axis_tvalid = out_valid_reg;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(out_data_reg);
  assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){out_valid_reg}};
  assign m00_axis_tlast  = out_last_reg;

endmodule

// File: tb/tb_fm_audio_decimator.sv
// Scoreboard bench for fm_audio_decimator: expected samples queued per window, popped on output handshakes.
module tb_fm_audio_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic [2:0]  decim;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mz;

  fm_audio_decimator dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .decim_log2       (decim),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tlast   (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] avg(input int unsigned sum, input int l);
    int unsigned r;
    r = (l == 0) ? sum : ((sum + (32'd1 << (l - 1))) >> l);
    return (r > 32'hFFFF) ? 16'hFFFF : r[15:0];
  endfunction

  task automatic push_exp(input logic [15:0] y, input logic last);
    exp_t e;
`ifdef FM_DEEMPH_EN
    begin
      int d;
      d  = int'(y) - int'(mz);
      mz = 16'(int'(mz) + (d >>> 3));
      y  = mz;
    end
`endif
    e.data = y;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send(input logic [15:0] d, input logic last, output int stalls);
    s_tvalid = 1'b1;
    s_tdata  = {16'h0, d};
    s_tlast  = last;
    stalls   = 0;
    while (1) begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      if (stalls > 200) begin
        check("s_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      $display("out data=%0d last=%0b", m_tdata[15:0], m_tlast);
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", m_tdata, {16'h0, mon_e.data});
        check("out_last", {31'h0, m_tlast}, {31'h0, mon_e.last});
        check("out_strb", {28'h0, m_tstrb}, 32'hF);
      end
    end
  end

  initial begin
    int st;
    int total;
    int unsigned sum;
    logic [15:0] v;

    s_tvalid = 1'b0; s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0;
    decim = 3'd2; m_tready = 1'b1; mz = '0;

    #1;
    check("rst_s_ready", {31'h0, s_tready}, 32'd0);
    check("rst_m_valid", {31'h0, m_tvalid}, 32'd0);
    check("rst_m_data", m_tdata, 32'd0);
    check("rst_m_strb", {28'h0, m_tstrb}, 32'd0);
    check("rst_m_last", {31'h0, m_tlast}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", {31'h0, s_tready}, 32'd1);
    @(posedge clk);
    #1;

    // pending output plus a half window, then asynchronous reset between edges
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'd20, 1'b0, st);
    push_exp(avg(80, 2), 1'b0);
    @(negedge clk);
    check("pend_valid", {31'h0, m_tvalid}, 32'd1);
    @(posedge clk);
    #1;
    total = 0;
    for (int i = 0; i < 2; i++) begin
      send(16'd7, 1'b0, st);
      total += st;
    end
    check("nonfinal_ready_when_full", total, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, m_tvalid}, 32'd0);
    check("async_rst_data", m_tdata, 32'd0);
    check("async_rst_s_ready", {31'h0, s_tready}, 32'd0);
    exp_q.delete();
    mz = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(16'd100, 1'b0, st);
    push_exp(avg(400, 2), 1'b0);

    // rounding
    send(16'd1, 1'b0, st); send(16'd2, 1'b0, st); send(16'd3, 1'b0, st); send(16'd4, 1'b0, st);
    push_exp(avg(10, 2), 1'b0);
    send(16'd0, 1'b0, st); send(16'd0, 1'b0, st); send(16'd0, 1'b0, st); send(16'd1, 1'b0, st);
    push_exp(avg(1, 2), 1'b0);
    send(16'd0, 1'b0, st); send(16'd0, 1'b0, st); send(16'd1, 1'b0, st); send(16'd1, 1'b0, st);
    push_exp(avg(2, 2), 1'b0);
    wait_drain();

    // bypass with backpressure
    decim = 3'd0;
    m_tready = 1'b0;
    send(16'd5, 1'b0, st);
    push_exp(avg(5, 0), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd6;
    repeat (3) begin
      @(negedge clk);
      check("bp_s_ready", {31'h0, s_tready}, 32'd0);
      check("bp_hold_valid", {31'h0, m_tvalid}, 32'd1);
      check("bp_hold_data", m_tdata, {16'h0, exp_q[0].data});
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    send(16'd6, 1'b0, st);
    push_exp(avg(6, 0), 1'b0);
    send(16'd7, 1'b0, st);
    push_exp(avg(7, 0), 1'b0);
    wait_drain();

    // full scale; decim change mid-window must not take effect until next window
    decim = 3'd6;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) decim = 3'd1;
      send(16'hFFFF, 1'b0, st);
    end
    push_exp(avg(64 * 32'hFFFF, 6), 1'b0);
    send(16'd10, 1'b0, st);
    send(16'd13, 1'b0, st);
    push_exp(avg(23, 1), 1'b0);

    // tlast in the middle of a window
    decim = 3'd3;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'(10 * i), i == 2, st);
      sum += 10 * i;
    end
    push_exp(avg(sum, 3), 1'b1);

    // throughput at L=3 with continuous downstream ready
    total = 0;
    for (int w = 0; w < 8; w++) begin
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        v = 16'($urandom_range(0, 65535));
        send(v, 1'b0, st);
        total += st;
        sum += v;
      end
      push_exp(avg(sum, 3), 1'b0);
    end
    check("thru_stalls", total, 32'd0);

    // request above MAX_LOG2 saturates to a 64-beat window
    decim = 3'd7;
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      send(16'(i * 1000), 1'b0, st);
      sum += i * 1000;
    end
    push_exp(avg(sum, 6), 1'b0);
    wait_drain();

    // L=0 stream from a freshly reset filter state
    rst_n = 1'b0;
    mz = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    decim = 3'd0;
    for (int i = 0; i < 3; i++) begin
      send(16'd800, 1'b0, st);
      push_exp(avg(800, 0), 1'b0);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
